// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding and frame field sizes for the SPI register bridge
package spi_reg_pkg;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_WAIT, DATA, DONE, ERR} state_t;

    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int DATA_BITS    = 16;
    localparam int CMD_READ_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // shift the async input through the synchronizer and keep one delayed copy for edges
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave turning 32-bit frames into register strobes; SPI_REG_AUTO_INCREMENT_EN enables burst mode
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              reg_write_en,
    output logic              reg_read_en,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              frame_err
);
    import spi_reg_pkg::*;

    localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
    localparam logic [3:0] ADDR_LAST = 4'(ADDR_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

    state_t                 state, state_next;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   rx, rx_next, tx;
    logic                   is_read;
    logic                   sclk_rise, sclk_fall, sclk_level_unused;
    logic                   cs_rise, cs_fall, cs_level_unused;
    logic                   mosi, mosi_rise_unused, mosi_fall_unused;
    logic                   shift_en, tx_shift, cnt_clr, cmd_load, addr_load, tx_load;
    logic                   wr_pulse, rd_pulse, err_pulse, done_now, partial_ok, abortable;

    // CS_n synchronizer resets to "selected" so a reset in mid-frame never fakes a start edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign rx_next   = {rx[DATA_BITS-2:0], mosi};
    assign shift_en  = sclk_rise && (state inside {CMD, ADDR, DATA});
    assign tx_shift  = sclk_fall && state == DATA;
    assign abortable = state inside {CMD, ADDR, RD_WAIT, DATA};
    assign busy      = state != IDLE;

`ifdef SPI_REG_AUTO_INCREMENT_EN
    logic word_done;
    assign partial_ok = done_now | word_done;
    // remembers that a full word landed, so a trailing partial word is not an error
    always_ff @(posedge clk) begin
        if (reset || state == IDLE)
            word_done <= 1'b0;
        else if (done_now)
            word_done <= 1'b1;
    end
`else
    assign partial_ok = done_now;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state and per-cycle control; a same-cycle CS_n rise is applied after the SCLK edge
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cmd_load   = 1'b0;
        addr_load  = 1'b0;
        tx_load    = 1'b0;
        wr_pulse   = 1'b0;
        rd_pulse   = 1'b0;
        err_pulse  = 1'b0;
        done_now   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr    = cs_fall;
                state_next = cs_fall ? CMD : IDLE;
            end
            CMD: if (sclk_rise && bit_cnt == CMD_LAST) begin
                cnt_clr    = 1'b1;
                cmd_load   = 1'b1;
                err_pulse  = |rx_next[CMD_READ_BIT-1:0];
                state_next = err_pulse ? ERR : ADDR;
            end
            ADDR: if (sclk_rise && bit_cnt == ADDR_LAST) begin
                cnt_clr    = 1'b1;
                addr_load  = 1'b1;
                rd_pulse   = is_read;
                state_next = is_read ? RD_WAIT : DATA;
            end
            RD_WAIT: if (!reg_read_en) begin
                tx_load    = 1'b1;
                state_next = DATA;
            end
            DATA: if (sclk_rise && bit_cnt == DATA_LAST) begin
                cnt_clr    = 1'b1;
                done_now   = 1'b1;
                wr_pulse   = !is_read;
`ifdef SPI_REG_AUTO_INCREMENT_EN
                rd_pulse   = is_read;
                state_next = is_read ? RD_WAIT : DATA;
`else
                state_next = DONE;
`endif
            end
            default: ;
        endcase
        if (cs_rise && state != IDLE) begin
            err_pulse  = err_pulse | (abortable && !partial_ok);
            rd_pulse   = 1'b0;
            state_next = IDLE;
        end
    end

    // datapath: shifters, bit counter, register-file strobes and MISO
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            rx           <= '0;
            tx           <= '0;
            is_read      <= 1'b0;
            spi_miso     <= 1'b0;
            reg_write_en <= 1'b0;
            reg_read_en  <= 1'b0;
            reg_address  <= '0;
            reg_wdata    <= '0;
            frame_err    <= 1'b0;
        end else begin
            reg_write_en <= wr_pulse;
            reg_read_en  <= rd_pulse;
            frame_err    <= err_pulse;
            bit_cnt      <= cnt_clr ? 4'd0 : shift_en ? bit_cnt + 1'b1 : bit_cnt;
            if (shift_en)
                rx <= rx_next;
            if (cmd_load)
                is_read <= rx_next[CMD_READ_BIT];
            if (addr_load)
                reg_address <= ADDR_W'(rx_next[ADDR_BITS-1:0]);
`ifdef SPI_REG_AUTO_INCREMENT_EN
            else if (reg_write_en || (rd_pulse && state == DATA))
                reg_address <= reg_address + 1'b1;
`endif
            if (wr_pulse)
                reg_wdata <= DATA_W'(rx_next);
            tx       <= state == IDLE ? '0 : tx_load ? DATA_BITS'(reg_rdata) : tx_shift ? {tx[DATA_BITS-2:0], 1'b0} : tx;
            spi_miso <= state_next == IDLE ? 1'b0 : tx_shift ? tx[DATA_BITS-1] : spi_miso;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: randomized SPI host with a frame-level reference model and an event scoreboard
module tb_spi_reg_bridge;

    localparam int H = 10;
`ifdef SPI_REG_AUTO_INCREMENT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, reg_write_en, reg_read_en, busy, frame_err;
    logic [7:0]  reg_address;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = '0;
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    ev_t         exp_q [$];
    int          total = 0, bad = 0;

    spi_reg_bridge dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
        .reg_address(reg_address), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // register file model: synchronous write, read data one clock after the strobe
    always @(posedge clk) begin
        if (reg_write_en)
            mem[reg_address] <= reg_wdata;
        if (reg_read_en)
            reg_rdata <= mem[reg_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] addr, input logic [15:0] data);
        exp_q.push_back('{kind, addr, data});
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind, 0);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == e.kind && kind != 3)
            check("event_addr", addr, e.addr);
        if (kind == e.kind && kind == 1)
            check("event_wdata", data, e.data);
    endtask

    // monitor: every strobe the DUT presents is matched against the next expected event
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_write_en && reg_read_en)
                check("rw_same_cycle", 1, 0);
            if (reg_read_en)
                expect_ev(2, reg_address, 16'h0);
            if (reg_write_en)
                expect_ev(1, reg_address, reg_wdata);
            if (frame_err)
                expect_ev(3, 8'h0, 16'h0);
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // frame-level model: which strobes/errors a frame of nb bits must produce, and the read words
    task automatic model(input logic [7:0] cmd, input logic [7:0] addr, input logic [63:0] wds,
                         input int nb, input bit tie, output logic [63:0] rd_exp, output int nrd);
        int full;
        logic [7:0] a;
        logic [15:0] w;
        rd_exp = '0;
        nrd = 0;
        if (nb >= 8 && cmd[6:0] != 7'd0) begin
            push(3, 8'h0, 16'h0);
            return;
        end
        if (nb < 16) begin
            push(3, 8'h0, 16'h0);
            return;
        end
        full = (nb - 16) / 16;
        if (!AUTO && full > 1)
            full = 1;
        if (cmd[7])
            push(2, addr, 16'h0);
        if (full == 0) begin
            push(3, 8'h0, 16'h0);
            return;
        end
        for (int k = 0; k < full; k++) begin
            a = addr + 8'(k);
            w = wds[63-16*k -: 16];
            if (cmd[7]) begin
                rd_exp[63-16*k -: 16] = ref_mem[a];
                if (AUTO && !(tie && k == full - 1))
                    push(2, a + 8'd1, 16'h0);
            end else begin
                push(1, a, w);
                ref_mem[a] = w;
            end
        end
        nrd = cmd[7] ? full : 0;
    endtask

    // SPI mode-0 host: MOSI set while SCLK low, MISO captured at each rising edge
    task automatic run_frame(input logic [95:0] fr, input int nb, input bit tie, input int rst_at,
                             output logic [95:0] got);
        got = '0;
        check("idle_miso", spi_miso, 0);
        check("idle_busy", busy, 0);
        spi_cs_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nb; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                wait_clk(1);
                check("midframe_reset_outputs", {spi_miso, reg_write_en, reg_read_en, reg_address, reg_wdata, busy, frame_err}, 0);
                wait_clk(1);
                check("midframe_reset_busy", busy, 0);
                reset = 1'b0;
            end
            spi_mosi = fr[95-i];
            wait_clk(H);
            spi_sclk = 1'b1;
            got[95-i] = spi_miso;
            if (i == 0 && rst_at != 0)
                check("busy_in_frame", busy, 1);
            if (tie && i == nb - 1)
                spi_cs_n = 1'b1;
            wait_clk(H);
            spi_sclk = 1'b0;
        end
        wait_clk(H);
        spi_cs_n = 1'b1;
        wait_clk(4 * H);
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [63:0] wds,
                            input int nb, input bit tie);
        logic [63:0] rd_exp;
        logic [95:0] got;
        int nrd;
        model(cmd, addr, wds, nb, tie, rd_exp, nrd);
        run_frame({cmd, addr, wds, 16'h0}, nb, tie, -1, got);
        for (int k = 0; k < nrd; k++)
            check("miso_word", 32'(got[79-16*k -: 16]), 32'(rd_exp[63-16*k -: 16]));
    endtask

    initial begin
        logic [95:0] got;
        logic [7:0] cmd, addr;
        logic [63:0] wds;
        int nb, r;
        bit tie;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[0] = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;
        wait_clk(3);
        check("rst_miso", spi_miso, 0);
        check("rst_strobes", {reg_write_en, reg_read_en, frame_err}, 0);
        check("rst_address", reg_address, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        wait_clk(5);

        do_frame(8'h00, 8'h7F, {16'h1234, 48'h0}, 32, 1'b0);
        do_frame(8'h80, 8'h00, 64'h0, 32, 1'b0);
        do_frame(8'h00, 8'h33, {16'hCAFE, 48'h0}, 20, 1'b0);
        do_frame(8'h00, 8'h00, {16'h0001, 48'h0}, 32, 1'b0);
        do_frame(8'h41, 8'h12, {16'h5A5A, 48'h0}, 32, 1'b0);
        run_frame({8'h00, 8'h7F, 16'h0099, 64'h0}, 32, 1'b0, 12, got);
        do_frame(8'h00, 8'h7F, {16'h0005, 48'h0}, 32, 1'b0);
        do_frame(8'h00, 8'h44, {16'h8001, 48'h0}, 32, 1'b1);
        do_frame(8'h80, 8'h7F, 64'h0, 32, 1'b0);
`ifdef SPI_REG_AUTO_INCREMENT_EN
        do_frame(8'h00, 8'hFF, {16'hAAAA, 16'h5555, 32'h0}, 48, 1'b0);
        do_frame(8'h80, 8'hFF, 64'h0, 48, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 7);
            cmd = r < 3 ? 8'h00 : r < 6 ? 8'h80 : 8'($urandom);
            addr = 8'($urandom);
            wds = {$urandom, $urandom};
            if (AUTO) begin
                nb = 16 + 16 * int'($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0)
                    nb += int'($urandom_range(1, 15));
                tie = 1'b0;
            end else begin
                nb = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 40)) : 32;
                tie = nb == 32 && $urandom_range(0, 3) == 0;
            end
            do_frame(cmd, addr, wds, nb, tie);
        end

        wait_clk(50);
        check("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
